// File: rtl/auction_pkg.sv
// ----------------------------------------------------------------------------
// auction_pkg
// Shared definitions for the sequential auction controller:
//   - state_t    : controller states IDLE / COLLECT / SCAN / DONE
//   - RST_*      : values the controller loads on reset
//   - NB         : bidder count for the default N (2^N)
//   - bidder_count() : 2^n helper for parameterised instances
// ----------------------------------------------------------------------------
package auction_pkg;

    localparam int N_DEFAULT = 3;
    localparam int W_DEFAULT = 3;

    function automatic int bidder_count(input int n);
        return 1 << n;
    endfunction

    localparam int NB = bidder_count(N_DEFAULT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SCAN    = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam state_t RST_STATE = IDLE;
    localparam logic   RST_FLAG  = 1'b0;

endpackage

// File: rtl/auction_bid_bank.sv
// ----------------------------------------------------------------------------
// auction_bid_bank
// 2^N x W bid register file plus a per-bidder "submitted" mask.
// Only the first write per bidder is stored; a later write to an id whose
// mask bit is already set is dropped and flagged through o_dup.
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset (clears bank and mask)
//   i_clr       : synchronous clear of bank and mask (new round)
//   i_we        : write strobe (one accepted bid transfer)
//   i_wid       : bidder index of the write
//   i_wdata     : bid value of the write
//   i_rid       : read index (scan pointer)
//   o_rdata     : stored value at i_rid (combinational)
//   o_rvalid    : mask bit at i_rid (combinational)
//   o_dup       : current write targets an id that already bid
// ----------------------------------------------------------------------------
module auction_bid_bank
    import auction_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_we,
    input  logic [N-1:0] i_wid,
    input  logic [W-1:0] i_wdata,
    input  logic [N-1:0] i_rid,
    output logic [W-1:0] o_rdata,
    output logic         o_rvalid,
    output logic         o_dup
);

    localparam int NBK = bidder_count(N);

    logic [W-1:0]   r_bank [NBK];
    logic [NBK-1:0] r_mask;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_mask <= '0;
            for (int i = 0; i < NBK; i++) begin
                r_bank[i] <= '0;
            end
        end else if (i_we && !r_mask[i_wid]) begin
            r_bank[i_wid] <= i_wdata;
            r_mask[i_wid] <= 1'b1;
        end
    end

    assign o_rdata  = r_bank[i_rid];
    assign o_rvalid = r_mask[i_rid];
    assign o_dup    = i_we && r_mask[i_wid];

endmodule

// File: rtl/auction_ctrl.sv
// ----------------------------------------------------------------------------
// auction_ctrl
// Sequential auction for 2^N bidders sharing one bid-entry port.
// COLLECT accepts one bid per bidder until all have bid or TIMEOUT cycles
// have elapsed since start; SCAN walks the bid bank one entry per cycle to
// find the highest bid (lowest index wins ties); DONE presents the result
// until res_ready.
//
// Build option: define SECOND_PRICE_EN for Vickrey pricing (winning_bid is
// the highest bid among the other bidders, 0 if there is only one bidder).
// Without it the winner pays its own bid.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : opens a round (only in IDLE)
//   bid_valid/bid_ready : bid handshake, bid_ready high only in COLLECT
//   bid_id, bid_value   : bidder index and unsigned bid
//   busy                : high in COLLECT and SCAN
//   res_valid/res_ready : result handshake, res_valid high only in DONE
//   winner, winning_bid : winning index and price
//   no_bid              : round closed with zero bids
//   num_bids            : distinct bidders accepted this round
//   dup_err             : a duplicate bid was dropped this round (sticky)
// ----------------------------------------------------------------------------
module auction_ctrl
    import auction_pkg::*;
#(
    parameter int N       = N_DEFAULT,
    parameter int W       = W_DEFAULT,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         bid_valid,
    output logic         bid_ready,
    input  logic [N-1:0] bid_id,
    input  logic [W-1:0] bid_value,
    output logic         busy,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] winner,
    output logic [W-1:0] winning_bid,
    output logic         no_bid,
    output logic [N:0]   num_bids,
    output logic         dup_err
);

    localparam int NBIDS = bidder_count(N);
    localparam int TW    = $clog2(TIMEOUT) + 1;

    state_t         r_state;
    logic [TW-1:0]  r_timer;
    logic [N-1:0]   r_idx;
    logic [N:0]     r_num_bids;
    logic           r_dup_err;
    logic [N-1:0]   r_winner;
    logic [W-1:0]   r_winning_bid;
    logic           r_no_bid;

    // Running maximum during SCAN
    logic           r_best_vld;
    logic [N-1:0]   r_best_idx;
    logic [W-1:0]   r_best_val;

    logic           w_collect;
    logic           w_xfer;
    logic           w_clr;
    logic           w_dup;
    logic           w_new_bid;
    logic [N:0]     w_num_next;
    logic           w_close;
    logic [W-1:0]   w_rd_val;
    logic           w_rd_vld;
    logic           w_take;
    logic           w_best_vld_n;
    logic [N-1:0]   w_best_idx_n;
    logic [W-1:0]   w_best_val_n;
    logic [W-1:0]   w_price;

    assign w_collect  = (r_state == COLLECT);
    assign w_xfer     = bid_valid && w_collect;
    assign w_clr      = (r_state == IDLE) && start;
    assign w_new_bid  = w_xfer && !w_dup;
    assign w_num_next = r_num_bids + (N+1)'(w_new_bid);
    // A transfer on the closing cycle is already folded into w_num_next.
    assign w_close    = w_collect &&
                        ((w_num_next == (N+1)'(NBIDS)) || (r_timer == TW'(TIMEOUT - 1)));

    auction_bid_bank #(
        .N (N),
        .W (W)
    ) u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_clr),
        .i_we     (w_xfer),
        .i_wid    (bid_id),
        .i_wdata  (bid_value),
        .i_rid    (r_idx),
        .o_rdata  (w_rd_val),
        .o_rvalid (w_rd_vld),
        .o_dup    (w_dup)
    );

    // Strict greater-than keeps the earlier (lower) index on ties.
    assign w_take       = w_rd_vld && (!r_best_vld || (w_rd_val > r_best_val));
    assign w_best_vld_n = r_best_vld || w_rd_vld;
    assign w_best_idx_n = w_take ? r_idx    : r_best_idx;
    assign w_best_val_n = w_take ? w_rd_val : r_best_val;

`ifdef SECOND_PRICE_EN
    logic         r_sec_vld;
    logic [W-1:0] r_sec_val;
    logic         w_sec_vld_n;
    logic [W-1:0] w_sec_val_n;

    // Runner-up: a displaced best becomes second; otherwise a non-winning
    // entry (including one equal to the best) competes for second place.
    always_comb begin
        w_sec_vld_n = r_sec_vld;
        w_sec_val_n = r_sec_val;
        if (w_take && r_best_vld) begin
            w_sec_vld_n = 1'b1;
            w_sec_val_n = r_best_val;
        end else if (w_rd_vld && !w_take) begin
            if (!r_sec_vld || (w_rd_val > r_sec_val)) begin
                w_sec_vld_n = 1'b1;
                w_sec_val_n = w_rd_val;
            end
        end
    end

    assign w_price = w_sec_vld_n ? w_sec_val_n : '0;
`else
    // r_best_val is zeroed on SCAN entry, so an empty round prices at 0.
    assign w_price = w_best_val_n;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= RST_STATE;
            r_timer       <= '0;
            r_idx         <= '0;
            r_num_bids    <= '0;
            r_dup_err     <= RST_FLAG;
            r_winner      <= '0;
            r_winning_bid <= '0;
            r_no_bid      <= RST_FLAG;
            r_best_vld    <= RST_FLAG;
            r_best_idx    <= '0;
            r_best_val    <= '0;
`ifdef SECOND_PRICE_EN
            r_sec_vld     <= RST_FLAG;
            r_sec_val     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= COLLECT;
                        r_timer    <= '0;
                        r_num_bids <= '0;
                        r_dup_err  <= 1'b0;
                    end
                end
                COLLECT: begin
                    r_timer    <= r_timer + TW'(1);
                    r_num_bids <= w_num_next;
                    if (w_xfer && w_dup) begin
                        r_dup_err <= 1'b1;
                    end
                    if (w_close) begin
                        r_state    <= SCAN;
                        r_idx      <= '0;
                        r_best_vld <= 1'b0;
                        r_best_idx <= '0;
                        r_best_val <= '0;
`ifdef SECOND_PRICE_EN
                        r_sec_vld  <= 1'b0;
                        r_sec_val  <= '0;
`endif
                    end
                end
                SCAN: begin
                    r_idx      <= r_idx + N'(1);
                    r_best_vld <= w_best_vld_n;
                    r_best_idx <= w_best_idx_n;
                    r_best_val <= w_best_val_n;
`ifdef SECOND_PRICE_EN
                    r_sec_vld  <= w_sec_vld_n;
                    r_sec_val  <= w_sec_val_n;
`endif
                    if (r_idx == N'(NBIDS - 1)) begin
                        r_state       <= DONE;
                        r_winner      <= w_best_vld_n ? w_best_idx_n : '0;
                        r_winning_bid <= w_price;
                        r_no_bid      <= (r_num_bids == '0);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bid_ready   = w_collect;
    assign busy        = w_collect || (r_state == SCAN);
    assign res_valid   = (r_state == DONE);
    assign winner      = r_winner;
    assign winning_bid = r_winning_bid;
    assign no_bid      = r_no_bid;
    assign num_bids    = r_num_bids;
    assign dup_err     = r_dup_err;

endmodule

// File: tb/tb_auction_ctrl.sv
// ----------------------------------------------------------------------------
// tb_auction_ctrl
// Scenario tasks drive rounds through auction_ctrl and compare the result
// against a reference model that works from the whole list of bids
// (first bid per bidder kept, max value, lowest index among the maxima).
// ----------------------------------------------------------------------------
module tb_auction_ctrl;

    localparam int N       = 3;
    localparam int W       = 3;
    localparam int TIMEOUT = 15;
    localparam int NB      = 1 << N;

`ifdef SECOND_PRICE_EN
    localparam bit SP = 1'b1;
`else
    localparam bit SP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         bid_valid = 1'b0;
    logic         bid_ready;
    logic [N-1:0] bid_id = '0;
    logic [W-1:0] bid_value = '0;
    logic         busy;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [N-1:0] winner;
    logic [W-1:0] winning_bid;
    logic         no_bid;
    logic [N:0]   num_bids;
    logic         dup_err;

    auction_ctrl #(
        .N       (N),
        .W       (W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bid_valid   (bid_valid),
        .bid_ready   (bid_ready),
        .bid_id      (bid_id),
        .bid_value   (bid_value),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .winner      (winner),
        .winning_bid (winning_bid),
        .no_bid      (no_bid),
        .num_bids    (num_bids),
        .dup_err     (dup_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus for the next round
    int q_id[$];
    int q_val[$];

    // Model expectations
    int exp_winner, exp_price, exp_num, exp_collect, exp_sent;
    bit exp_no_bid, exp_dup;

    task automatic model_round();
        bit seen[NB];
        int val[NB];
        int maxv;
        int p;
        for (int i = 0; i < NB; i++) begin
            seen[i] = 1'b0;
            val[i]  = 0;
        end
        exp_num  = 0;
        exp_dup  = 1'b0;
        exp_sent = 0;
        for (int k = 0; k < q_id.size(); k++) begin
            if (exp_num == NB) break;   // round closed; later bids never sent
            exp_sent++;
            if (seen[q_id[k]]) begin
                exp_dup = 1'b1;
            end else begin
                seen[q_id[k]] = 1'b1;
                val[q_id[k]]  = q_val[k];
                exp_num++;
            end
        end
        exp_collect = (exp_num == NB) ? exp_sent : TIMEOUT;
        exp_no_bid  = (exp_num == 0);
        exp_winner  = 0;
        exp_price   = 0;
        if (!exp_no_bid) begin
            maxv = -1;
            for (int i = 0; i < NB; i++)
                if (seen[i] && val[i] > maxv) maxv = val[i];
            for (int i = 0; i < NB; i++) begin
                if (seen[i] && val[i] == maxv) begin
                    exp_winner = i;
                    break;
                end
            end
            if (SP) begin
                p = 0;
                for (int j = 0; j < NB; j++)
                    if (seen[j] && j != exp_winner && val[j] > p) p = val[j];
                exp_price = p;
            end else begin
                exp_price = maxv;
            end
        end
    endtask

    // Runs one round from start to result consumption, comparing handshake
    // timing and result fields against the model values.
    task automatic run_round(input bit poke_start, input int hold);
        int cyc;
        int cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        for (int k = 0; k < exp_sent; k++) begin
            n_checks++;
            if (bid_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL bid_ready_k%0d: got %b expected 1", k, bid_ready);
            end
            bid_valid = 1'b1;
            bid_id    = N'(q_id[k]);
            bid_value = W'(q_val[k]);
            cyc++;
            @(negedge clk);
        end
        bid_valid = 1'b0;
        while (bid_ready === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        n_checks++;
        if (cyc != exp_collect) begin
            n_fail++;
            $display("FAIL collect_len: got %0d expected %0d", cyc, exp_collect);
        end
        cnt = 0;
        while (res_valid !== 1'b1 && cnt < 100) begin
            start = (poke_start && cnt == 2);
            cnt++;
            @(negedge clk);
        end
        start = 1'b0;
        n_checks++;
        if (cnt != NB) begin
            n_fail++;
            $display("FAIL scan_len: got %0d expected %0d", cnt, NB);
        end
        n_checks++;
        if (winner !== N'(exp_winner) || winning_bid !== W'(exp_price) ||
            no_bid !== exp_no_bid || num_bids !== (N+1)'(exp_num) ||
            dup_err !== exp_dup || busy !== 1'b0 || bid_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL result: got win=%0d price=%0d nob=%b num=%0d dup=%b busy=%b rdy=%b expected win=%0d price=%0d nob=%b num=%0d dup=%b busy=0 rdy=0",
                     winner, winning_bid, no_bid, num_bids, dup_err, busy, bid_ready,
                     exp_winner, exp_price, exp_no_bid, exp_num, exp_dup);
        end
        for (int h = 0; h < hold; h++) begin
            start = poke_start;
            @(negedge clk);
            start = 1'b0;
            n_checks++;
            if (res_valid !== 1'b1 || winner !== N'(exp_winner) ||
                winning_bid !== W'(exp_price) || no_bid !== exp_no_bid ||
                num_bids !== (N+1)'(exp_num)) begin
                n_fail++;
                $display("FAIL hold_%0d: got vld=%b win=%0d price=%0d nob=%b num=%0d expected vld=1 win=%0d price=%0d nob=%b num=%0d",
                         h, res_valid, winner, winning_bid, no_bid, num_bids,
                         exp_winner, exp_price, exp_no_bid, exp_num);
            end
        end
        res_ready = 1'b1;
        start     = poke_start;
        @(negedge clk);
        res_ready = 1'b0;
        start     = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || bid_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL consume: got vld=%b busy=%b rdy=%b expected 0 0 0",
                     res_valid, busy, bid_ready);
        end
        @(negedge clk);
        n_checks++;
        if (bid_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after: got rdy=%b busy=%b expected 0 0", bid_ready, busy);
        end
        $display("round: bids=%0d sent=%0d winner=%0d price=%0d num=%0d no_bid=%b dup=%b",
                 q_id.size(), exp_sent, winner, winning_bid, num_bids, no_bid, dup_err);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bid_ready, busy, res_valid, winner, winning_bid, no_bid, num_bids, dup_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b vld=%b win=%0d price=%0d nob=%b num=%0d dup=%b expected all 0",
                     bid_ready, busy, res_valid, winner, winning_bid, no_bid, num_bids, dup_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_round();
        int vals[8] = '{6, 0, 1, 4, 3, 7, 5, 2};
        q_id.delete();
        q_val.delete();
        for (int i = 0; i < 8; i++) begin
            q_id.push_back(i);
            q_val.push_back(vals[i]);
        end
        model_round();
        run_round(1'b0, 0);
        n_checks++;
        if (winner !== 3'd5 || winning_bid !== (SP ? 3'd6 : 3'd7) || num_bids !== 4'd8 || no_bid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_round: got win=%0d price=%0d num=%0d nob=%b expected win=5 price=%0d num=8 nob=0",
                     winner, winning_bid, num_bids, no_bid, SP ? 6 : 7);
        end
    endtask

    task automatic test_tie();
        q_id  = '{2, 6};
        q_val = '{5, 5};
        model_round();
        run_round(1'b0, 0);
        n_checks++;
        if (winner !== 3'd2 || winning_bid !== 3'd5) begin
            n_fail++;
            $display("FAIL tie: got win=%0d price=%0d expected win=2 price=5", winner, winning_bid);
        end
    endtask

    task automatic test_partial();
        q_id  = '{1, 4};
        q_val = '{3, 6};
        model_round();
        run_round(1'b0, 1);
        n_checks++;
        if (winner !== 3'd4 || winning_bid !== (SP ? 3'd3 : 3'd6)) begin
            n_fail++;
            $display("FAIL partial: got win=%0d price=%0d expected win=4 price=%0d",
                     winner, winning_bid, SP ? 3 : 6);
        end
        q_id  = '{7};
        q_val = '{4};
        model_round();
        run_round(1'b0, 0);
        n_checks++;
        if (winner !== 3'd7 || winning_bid !== (SP ? 3'd0 : 3'd4) || num_bids !== 4'd1) begin
            n_fail++;
            $display("FAIL single: got win=%0d price=%0d num=%0d expected win=7 price=%0d num=1",
                     winner, winning_bid, num_bids, SP ? 0 : 4);
        end
    endtask

    task automatic test_no_bid();
        q_id.delete();
        q_val.delete();
        model_round();
        run_round(1'b0, 5);
        n_checks++;
        if (no_bid !== 1'b1 || winner !== 3'd0 || winning_bid !== 3'd0 || num_bids !== 4'd0) begin
            n_fail++;
            $display("FAIL no_bid: got nob=%b win=%0d price=%0d num=%0d expected nob=1 win=0 price=0 num=0",
                     no_bid, winner, winning_bid, num_bids);
        end
    endtask

    task automatic test_duplicate();
        q_id  = '{3, 3, 0};
        q_val = '{2, 7, 1};
        model_round();
        run_round(1'b1, 2);
        n_checks++;
        if (dup_err !== 1'b1 || winner !== 3'd3 || winning_bid !== (SP ? 3'd1 : 3'd2) || num_bids !== 4'd2) begin
            n_fail++;
            $display("FAIL duplicate: got dup=%b win=%0d price=%0d num=%0d expected dup=1 win=3 price=%0d num=2",
                     dup_err, winner, winning_bid, num_bids, SP ? 1 : 2);
        end
    endtask

    task automatic test_mid_reset();
        int ids[3]  = '{0, 1, 2};
        int vals[3] = '{7, 6, 5};
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bid_valid = 1'b1;
            bid_id    = N'(ids[k]);
            bid_value = W'(vals[k]);
            @(negedge clk);
        end
        bid_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if ({bid_ready, busy, res_valid, winner, winning_bid, no_bid, num_bids, dup_err} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got rdy=%b busy=%b vld=%b win=%0d price=%0d nob=%b num=%0d dup=%b expected all 0",
                     bid_ready, busy, res_valid, winner, winning_bid, no_bid, num_bids, dup_err);
        end
        // Low bids only: any stale entry from before the reset would win.
        q_id  = '{4, 5};
        q_val = '{1, 2};
        model_round();
        run_round(1'b0, 0);
        n_checks++;
        if (winner !== 3'd5 || num_bids !== 4'd2) begin
            n_fail++;
            $display("FAIL stale_bids: got win=%0d num=%0d expected win=5 num=2", winner, num_bids);
        end
        test_full_round();
    endtask

    task automatic test_random();
        int n;
        int perm[8];
        int j;
        int t;
        for (int r = 0; r < 20; r++) begin
            q_id.delete();
            q_val.delete();
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < NB; i++) perm[i] = i;
                for (int i = NB - 1; i > 0; i--) begin
                    j = $urandom_range(0, i);
                    t = perm[i];
                    perm[i] = perm[j];
                    perm[j] = t;
                end
                for (int i = 0; i < NB; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        q_id.push_back(perm[$urandom_range(0, NB - 1)]);
                        q_val.push_back($urandom_range(0, 7));
                    end
                    q_id.push_back(perm[i]);
                    q_val.push_back($urandom_range(0, 7));
                end
            end else begin
                n = $urandom_range(0, 12);
                for (int i = 0; i < n; i++) begin
                    q_id.push_back($urandom_range(0, NB - 1));
                    q_val.push_back($urandom_range(0, 7));
                end
            end
            model_round();
            run_round(1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_full_round();
        test_tie();
        test_partial();
        test_no_bid();
        test_duplicate();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
